load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width; parameter AWIDTH, default 32, address width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-003 Upstream ports from execute: ex_valid_i  in  1  op present; ex_ready_o  out  1  unit can accept; opcode_i  in  7; funct3_i  in  3; addr_i  in  AWIDTH  ALU result used as address or passthrough data; store_data_i  in  DWIDTH  rs2 value; rd_i  in  5  destination register.
REQ-004 Memory ports: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  AWIDTH  word-aligned; mem_be_o  out  4  byte enables; mem_wdata_o  out  DWIDTH  lane-shifted; mem_gnt_i  in  1  request accepted; mem_rvalid_i  in  1  read data valid; mem_rdata_i  in  DWIDTH.
REQ-005 Writeback ports: wb_valid_o  out  1; wb_ready_i  in  1; wb_data_o  out  DWIDTH; wb_rd_o  out  5; wb_misaligned_o  out  1  address fault flag.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-007 IDLE: ex_ready_o=1; on ex_valid_i the op, address, data, rd SHALL be captured in registers.
REQ-008 Non-memory opcode accepted in IDLE -> DONE next cycle, wb_data_o=addr_i, wb_misaligned_o=0 (1-cycle latency).
REQ-009 Load/store accepted in IDLE: misaligned (LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0) -> DONE, no memory request, wb_misaligned_o=1, wb_data_o=0; otherwise -> REQ.
REQ-010 REQ: mem_req_o=1, mem_addr_o={addr[AWIDTH-1:2],2'b00}, held stable until mem_gnt_i=1; on grant store -> DONE, load -> WAIT.
REQ-011 Stores: SB mem_be_o=4'b0001<<addr[1:0], wdata byte replicated to all lanes; SH mem_be_o=4'b0011<<addr[1:0], halfword replicated; SW mem_be_o=4'b1111; mem_we_o=1.
REQ-012 Loads: mem_we_o=0, mem_be_o per REQ-011 rules; mem_rvalid_i accepted only in WAIT, never in the grant cycle; rvalid in any other state SHALL be ignored.
REQ-013 WAIT: on mem_rvalid_i, selected byte/halfword SHALL be extracted by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; result registered -> DONE.
REQ-014 DONE: wb_valid_o=1 with wb_data_o, wb_rd_o, wb_misaligned_o stable until wb_ready_i=1; then -> IDLE. Stores report wb_rd_o=0, wb_data_o=0.
REQ-015 ex_ready_o SHALL be 0 in REQ, WAIT, DONE; ex_valid_i ignored there (no back-to-back overlap).
REQ-016 All outputs except ex_ready_o SHALL be driven from registers or state decode only; no combinational path from mem_rdata_i to wb_data_o.
REQ-017 Unsupported funct3 on load/store opcode SHALL be treated as non-memory passthrough with wb_misaligned_o=0.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately force state IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, wb_valid_o=0, wb_misaligned_o=0, mem_addr_o/mem_wdata_o/wb_data_o=0, wb_rd_o=0, ex_ready_o=1.
REQ-019 Reset mid-transaction (REQ or WAIT) SHALL abandon the op; a later mem_rvalid_i SHALL be ignored.

Structure
REQ-020 Opcode constants (OPCODE_LOAD, OPCODE_STORE), funct3 width encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and enum lsu_state_e SHALL live in the shared constants package.
REQ-021 Load extraction/extension SHALL be one combinational sub-module, load_align (inputs rdata, addr[1:0], funct3; output DWIDTH result).

Verification
REQ-022 SW addr=0x104 data=0xDEADBEEF, gnt same cycle as req -> mem_be_o=4'b1111, mem_addr_o=0x104, wb_valid_o 2 cycles after accept, wb_rd_o=0.
REQ-023 LB addr=0x203, rdata=0x80FF1234, rvalid 3 cycles after gnt -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-024 LH addr=0x301 -> no mem_req_o, wb_misaligned_o=1, wb_data_o=0 next cycle.
REQ-025 ADD result 0x1234, rd=5, wb_ready_i low 4 cycles -> wb_valid_o held 4+ cycles, data stable, ex_ready_o=0 until handshake.
REQ-026 LW grant stalled 5 cycles, rst_n pulsed low in WAIT, then stray rvalid -> outputs at reset values, no wb_valid_o.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: opcodes, width encodings,
// FSM state type and small lane helpers.
package load_store_unit_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    // Low two funct3 bits encode access size for both signed and unsigned loads
    function automatic logic [3:0] byte_enable(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            2'b00:   byte_enable = 4'b0001 << off;
            2'b01:   byte_enable = 4'b0011 << off;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load data extraction: selects the addressed byte/halfword from the
// read word and sign- or zero-extends it.
module load_align
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] rdata_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        result_o = rdata_i;
        case (funct3_i)
            F3_LB:   result_o = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            F3_LBU:  result_o = {{(DWIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  result_o = {{(DWIDTH-16){1'b0}}, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute, a req/gnt/rvalid
// data memory port and writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    input  logic [4:0]        rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic [4:0]        wb_rd_o,
    output logic              wb_misaligned_o
);

    lsu_state_e state_q, state_d;

    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [AWIDTH-1:0] maddr_q, maddr_d;
    logic [3:0]        be_q, be_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic              mis_q, mis_d;

    logic              is_load;
    logic              is_store;
    logic              bad_align;
    logic [DWIDTH-1:0] store_lanes;
    logic [DWIDTH-1:0] load_result;

    // Unsupported funct3 on a memory opcode falls through as passthrough
    assign is_load = (opcode_i == OPCODE_LOAD) &&
        (funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign is_store = (opcode_i == OPCODE_STORE) &&
        (funct3_i inside {F3_SB, F3_SH, F3_SW});
    assign bad_align = misaligned(funct3_i[1:0], addr_i[1:0]);

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   store_lanes = {(DWIDTH/8){store_data_i[7:0]}};
            2'b01:   store_lanes = {(DWIDTH/16){store_data_i[15:0]}};
            default: store_lanes = store_data_i;
        endcase
    end

    load_align #(
        .DWIDTH(DWIDTH)
    ) u_align (
        .rdata_i (mem_rdata_i),
        .off_i   (off_q),
        .funct3_i(funct3_q),
        .result_o(load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    state_d = ((is_load || is_store) && !bad_align)
                        ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex_ready_o = (state_q == IDLE);
        mem_req_o  = (state_q == REQ);
        mem_we_o   = (state_q == REQ) && is_store_q;
        mem_be_o   = (state_q == REQ) ? be_q : 4'b0000;
        wb_valid_o = (state_q == DONE);
    end

    assign mem_addr_o      = maddr_q;
    assign mem_wdata_o     = wdata_q;
    assign wb_data_o       = wb_data_q;
    assign wb_rd_o         = rd_q;
    assign wb_misaligned_o = mis_q;

    always_comb begin
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        maddr_d    = maddr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = mis_q;
        if (state_q == IDLE && ex_valid_i) begin
            is_store_d = is_store;
            funct3_d   = funct3_i;
            off_d      = addr_i[1:0];
            maddr_d    = {addr_i[AWIDTH-1:2], 2'b00};
            be_d       = byte_enable(funct3_i[1:0], addr_i[1:0]);
            wdata_d    = is_store ? store_lanes : '0;
            rd_d       = is_store ? 5'd0 : rd_i;
            mis_d      = (is_load || is_store) && bad_align;
            wb_data_d  = (is_load || is_store) ? '0 : DWIDTH'(addr_i);
        end else if (state_q == WAIT && mem_rvalid_i) begin
            wb_data_d = load_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            maddr_q    <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            maddr_q    <= maddr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected
// memory requests and writebacks; a negedge monitor compares them.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_misaligned_o;

    load_store_unit #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .store_data_i   (store_data_i),
        .rd_i           (rd_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_data_o      (wb_data_o),
        .wb_rd_o        (wb_rd_o),
        .wb_misaligned_o(wb_misaligned_o)
    );

    always #5 clk = ~clk;

    int applied = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        int          lat;
        int          acc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    wb_exp_t  wbq[$];
    mem_exp_t memq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor
    int   first_cyc = 0;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_req_o) begin
            if (memq.size() == 0) begin
                fail_now("unexpected_mem_req");
            end else begin
                check("mem_addr", mem_addr_o, memq[0].addr);
                check("mem_we", 32'(mem_we_o), 32'(memq[0].we));
                check("mem_be", 32'(mem_be_o), 32'(memq[0].be));
                if (memq[0].we)
                    check("mem_wdata", mem_wdata_o, memq[0].wdata);
                if (mem_gnt_i) void'(memq.pop_front());
            end
        end
        if (wb_valid_o) begin
            if (!valid_prev) first_cyc = cyc;
            if (wbq.size() == 0) begin
                fail_now("unexpected_wb_valid");
            end else begin
                check("wb_data", wb_data_o, wbq[0].data);
                check("wb_rd", 32'(wb_rd_o), 32'(wbq[0].rd));
                check("wb_mis", 32'(wb_misaligned_o), 32'(wbq[0].mis));
                check("ex_ready_busy", 32'(ex_ready_o), 32'd0);
                if (wb_ready_i) begin
                    if (wbq[0].lat >= 0)
                        check("latency", 32'(first_cyc - wbq[0].acc + 1),
                              32'(wbq[0].lat));
                    void'(wbq.pop_front());
                end
            end
        end
        valid_prev = wb_valid_o && !wb_ready_i;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ex_ready"}, 32'(ex_ready_o), 32'd1);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be_o), 32'd0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        check({tag, "_wb_data"}, wb_data_o, 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, "_wb_mis"}, 32'(wb_misaligned_o), 32'd0);
    endtask

    task automatic do_op(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] sdata,
        input logic [4:0]  rd,
        input bit          mem,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [31:0] rdata,
        input bit          stray,
        input int          stall,
        input logic [31:0] exp_data,
        input logic [4:0]  exp_rd,
        input bit          exp_mis,
        input int          exp_lat,
        input logic [31:0] exp_maddr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata
    );
        int n;
        n = 0;
        while (!ex_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ex_ready_o) fail_now("timeout_ex_ready");
        wb_ready_i   = (stall == 0);
        ex_valid_i   = 1'b1;
        opcode_i     = op;
        funct3_i     = f3;
        addr_i       = addr;
        store_data_i = sdata;
        rd_i         = rd;
        if (mem)
            memq.push_back('{exp_maddr, op == OPCODE_STORE, exp_be, exp_wdata});
        @(posedge clk); #1;
        ex_valid_i   = 1'b0;
        addr_i       = 32'hFFFF_FFFF;
        store_data_i = 32'h0;
        wbq.push_back('{exp_data, exp_rd, exp_mis, exp_lat, cyc});
        if (mem) begin
            repeat (gnt_dly) begin
                @(posedge clk); #1;
            end
            mem_gnt_i = 1'b1;
            if (stray) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h1122_3344;
            end
            @(posedge clk); #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (op == OPCODE_LOAD) begin
                repeat (rv_dly - 1) begin
                    @(posedge clk); #1;
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rdata;
                @(posedge clk); #1;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'hA5A5_A5A5;
            end
        end
        if (stall > 0) begin
            n = 0;
            while (!wb_valid_o && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (stall) begin
                @(negedge clk);
                check("wb_valid_held", 32'(wb_valid_o), 32'd1);
                @(posedge clk); #1;
            end
            wb_ready_i = 1'b1;
        end
        n = 0;
        while (wbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (wbq.size() != 0) begin
            fail_now("timeout_wb");
            wbq.delete();
        end
        wb_ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n        = 1'b0;
        ex_valid_i   = 1'b0;
        opcode_i     = 7'd0;
        funct3_i     = 3'd0;
        addr_i       = 32'd0;
        store_data_i = 32'd0;
        rd_i         = 5'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        wb_ready_i   = 1'b1;
        #3;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SW aligned, grant in the request cycle
        do_op(OPCODE_STORE, F3_SW, 32'h104, 32'hDEAD_BEEF, 5'd7, 1, 0, 0,
              32'h0, 0, 0, 32'h0, 5'd0, 0, 2, 32'h104, 4'b1111, 32'hDEAD_BEEF);
        // LB / LBU at offset 3, rvalid three cycles after grant
        do_op(OPCODE_LOAD, F3_LB, 32'h203, 32'h0, 5'd3, 1, 0, 3,
              32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 5'd3, 0, -1,
              32'h200, 4'b1000, 32'h0);
        do_op(OPCODE_LOAD, F3_LBU, 32'h203, 32'h0, 5'd4, 1, 0, 3,
              32'h80FF_1234, 1, 0, 32'h0000_0080, 5'd4, 0, -1,
              32'h200, 4'b1000, 32'h0);
        // Misaligned LH: no request, fault flag next cycle
        do_op(OPCODE_LOAD, F3_LH, 32'h301, 32'h0, 5'd9, 0, 0, 0,
              32'h0, 0, 0, 32'h0, 5'd9, 1, 1, 32'h0, 4'b0, 32'h0);
        // Passthrough with writeback back-pressure
        do_op(OP_ADD, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 0, 0,
              32'h0, 0, 4, 32'h1234, 5'd5, 0, 1, 32'h0, 4'b0, 32'h0);
        do_op(OPCODE_STORE, F3_SB, 32'h102, 32'h1234_56A5, 5'd1, 1, 2, 0,
              32'h0, 0, 0, 32'h0, 5'd0, 0, 4, 32'h100, 4'b0100, 32'hA5A5_A5A5);
        do_op(OPCODE_STORE, F3_SH, 32'h106, 32'h1234_BEEF, 5'd2, 1, 0, 0,
              32'h0, 0, 0, 32'h0, 5'd0, 0, 2, 32'h104, 4'b1100, 32'hBEEF_BEEF);
        do_op(OPCODE_LOAD, F3_LH, 32'h402, 32'h0, 5'd10, 1, 0, 1,
              32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 5'd10, 0, -1,
              32'h400, 4'b1100, 32'h0);
        do_op(OPCODE_LOAD, F3_LHU, 32'h402, 32'h0, 5'd11, 1, 0, 1,
              32'h8001_7FFF, 0, 0, 32'h0000_8001, 5'd11, 0, -1,
              32'h400, 4'b1100, 32'h0);
        do_op(OPCODE_LOAD, F3_LW, 32'h500, 32'h0, 5'd12, 1, 1, 2,
              32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 5'd12, 0, -1,
              32'h500, 4'b1111, 32'h0);
        do_op(OPCODE_STORE, F3_SW, 32'h106, 32'h5555_5555, 5'd8, 0, 0, 0,
              32'h0, 0, 0, 32'h0, 5'd0, 1, 1, 32'h0, 4'b0, 32'h0);
        // Unsupported funct3 on a load opcode acts as passthrough
        do_op(OPCODE_LOAD, 3'b011, 32'h777, 32'h0, 5'd4, 0, 0, 0,
              32'h0, 0, 0, 32'h777, 5'd4, 0, 1, 32'h0, 4'b0, 32'h0);
        do_op(OPCODE_LOAD, F3_LB, 32'h201, 32'h0, 5'd13, 1, 0, 1,
              32'h80FF_1234, 0, 0, 32'h0000_0012, 5'd13, 0, -1,
              32'h200, 4'b0010, 32'h0);

        // LW, grant stalled, reset in WAIT, then a stray rvalid
        wb_ready_i   = 1'b1;
        ex_valid_i   = 1'b1;
        opcode_i     = OPCODE_LOAD;
        funct3_i     = F3_LW;
        addr_i       = 32'h600;
        rd_i         = 5'd6;
        memq.push_back('{32'h600, 1'b0, 4'b1111, 32'h0});
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("stalled_req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(posedge clk); #1;
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mem_rvalid_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_reset_outputs("post");
        check("memq_drained", 32'(memq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
